amdc_axil_status_regs: RTL

AXI4-Lite slave register file for inverter status and control: four read/write control words, one live status word, one sticky fault latch with write-1-to-clear, and a version word. It is the responder for the sequential write/read traffic the AXI master VIP issues. It sits in each inverter-interface IP behind the PS interconnect, so firmware can configure the inverter and latch faults through one address window.

---
 rtl/amdc_axil_status_regs_if.sv | 33 +++
 rtl/amdc_axil_status_regs.sv | 98 +++++++++
 2 files changed

// File: rtl/amdc_axil_status_regs_if.sv
// amdc_axil_status_regs_if: AXI4-Lite port bundle between the PS interconnect and the status register file
interface amdc_axil_status_regs_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/amdc_axil_status_regs.sv
// amdc_axil_status_regs: AXI4-Lite control words, live status, sticky W1C fault latch and version word
module amdc_axil_status_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] VERSION            = 32'h0001_0000
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  amdc_axil_status_regs_if.slave        s_axi,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] ctrl_out,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] status_in,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] fault_in,
  output logic                          fault_any
);
  logic                                   ready_en;
  logic                                   aw_held;
  logic                                   w_held;
  logic                                   commit;
  logic                                   ar_hs;
  logic [2:0]                             aw_idx;
  logic [2:0]                             ar_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]          wdata_q;
  logic [3:0]                             wstrb_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]          wmask;
  logic [C_S_AXI_DATA_WIDTH-1:0]          clr;
  logic [C_S_AXI_DATA_WIDTH-1:0]          fault;
  logic [C_S_AXI_DATA_WIDTH-1:0]          fault_nxt;
  logic [C_S_AXI_DATA_WIDTH-1:0]          rd_mux;
  logic [3:0][C_S_AXI_DATA_WIDTH-1:0]     ctrl;
  logic                                   unused_ok;
  // ready_en keeps every READY low for the first cycle out of reset
  assign s_axi.awready = ready_en && !aw_held && !s_axi.bvalid;
  assign s_axi.wready  = ready_en && !w_held && !s_axi.bvalid;
  assign s_axi.arready = ready_en && !s_axi.rvalid;
  assign commit        = aw_held && w_held;
  assign ar_hs         = s_axi.arvalid && s_axi.arready;
  assign ar_idx        = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1 -: 3];
  assign ctrl_out      = ctrl;
  assign unused_ok     = ^{s_axi.awprot, s_axi.arprot,
                           s_axi.awaddr[C_S_AXI_ADDR_WIDTH-4:0], s_axi.araddr[C_S_AXI_ADDR_WIDTH-4:0]};
  always_comb begin
    wmask     = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
    clr       = (commit && aw_idx == 3'd5) ? (wdata_q & wmask) : '0;
    fault_nxt = (fault & ~clr) | fault_in;
    rd_mux    = !ar_idx[2]       ? ctrl[ar_idx[1:0]] :
                ar_idx == 3'd4   ? status_in :
                ar_idx == 3'd5   ? fault :
                ar_idx == 3'd6   ? VERSION : '0;
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ready_en     <= 1'b0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      ctrl         <= '0;
      fault        <= '0;
      fault_any    <= 1'b0;
      s_axi.bvalid <= 1'b0;
      s_axi.bresp  <= 2'b00;
      s_axi.rvalid <= 1'b0;
      s_axi.rresp  <= 2'b00;
      s_axi.rdata  <= '0;
    end else begin
      ready_en  <= 1'b1;
      fault     <= fault_nxt;
      fault_any <= |fault_nxt;
      if (s_axi.awvalid && s_axi.awready) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1 -: 3];
      end
      if (s_axi.wvalid && s_axi.wready) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi.bvalid <= 1'b1;
        s_axi.bresp  <= aw_idx == 3'd7 ? 2'b10 : 2'b00;
        if (!aw_idx[2]) ctrl[aw_idx[1:0]] <= (ctrl[aw_idx[1:0]] & ~wmask) | (wdata_q & wmask);
      end else if (s_axi.bready) begin
        s_axi.bvalid <= 1'b0;
      end
      // rd_mux sees pre-commit register values, so a same-cycle write is not visible
      if (ar_hs) begin
        s_axi.rvalid <= 1'b1;
        s_axi.rdata  <= rd_mux;
        s_axi.rresp  <= ar_idx == 3'd7 ? 2'b10 : 2'b00;
      end else if (s_axi.rready) begin
        s_axi.rvalid <= 1'b0;
      end
    end
  end
endmodule
